common_lib_pulse_rr_arbiter: RTL

// Collects event pulses from NB_SRC independent sources and shares one rdy/vld output among them.

---
 rtl/common_lib_pulse_rr_arbiter.sv | 125 ++++++++++++
 1 files changed

// File: rtl/common_lib_pulse_rr_arbiter.sv
// common_lib_pulse_rr_arbiter
// Collects one-cycle event pulses from NB_SRC sources into per-source pending
// counters and drains them one event per beat through a single vld/rdy output,
// scheduling sources round-robin. The output register carries the source index.
// An event arriving at a saturated counter is dropped and flagged on error.
module common_lib_pulse_rr_arbiter #(
    parameter int unsigned NB_SRC = 4,
    parameter int unsigned CNT_W  = 4,
    localparam int unsigned ID_W  = (NB_SRC > 1) ? $clog2(NB_SRC) : 1
) (
    input  logic              clk,
    input  logic              s_rst_n,
    input  logic [NB_SRC-1:0] in_pulse,
    output logic              out_vld,
    input  logic              out_rdy,
    output logic [ID_W-1:0]   out_id,
    output logic [NB_SRC-1:0] error
);

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [ID_W-1:0]  LAST_RST = ID_W'(NB_SRC - 1);

    if (NB_SRC < 2) begin : g_chk_nb_src
        $fatal(1, "common_lib_pulse_rr_arbiter: NB_SRC must be >= 2");
    end
    if (CNT_W < 1) begin : g_chk_cnt_w
        $fatal(1, "common_lib_pulse_rr_arbiter: CNT_W must be >= 1");
    end

    logic [CNT_W-1:0]  r_cnt [NB_SRC];
    logic              r_vld;
    logic [ID_W-1:0]   r_id;
    logic [ID_W-1:0]   r_last;
    logic [NB_SRC-1:0] r_err;

    logic              w_free;
    logic [NB_SRC-1:0] w_nz;
    logic              w_found_hi;
    logic [ID_W-1:0]   w_sel_hi;
    logic              w_found_lo;
    logic [ID_W-1:0]   w_sel_lo;
    logic              w_found;
    logic [ID_W-1:0]   w_sel;
    logic [NB_SRC-1:0] w_load;

    assign w_free = ~r_vld | out_rdy;

    // Round-robin pick: first non-empty source above r_last, else first from 0.
    // Split into two priority scans so no modulo is needed on the index.
    always_comb begin
        w_nz       = '0;
        w_found_hi = 1'b0;
        w_sel_hi   = '0;
        w_found_lo = 1'b0;
        w_sel_lo   = '0;
        for (int unsigned i = 0; i < NB_SRC; i++) begin
            w_nz[i] = (r_cnt[i] != '0);
        end
        for (int unsigned i = 0; i < NB_SRC; i++) begin
            if (!w_found_hi && w_nz[i] && (ID_W'(i) > r_last)) begin
                w_found_hi = 1'b1;
                w_sel_hi   = ID_W'(i);
            end
            if (!w_found_lo && w_nz[i]) begin
                w_found_lo = 1'b1;
                w_sel_lo   = ID_W'(i);
            end
        end
        w_found = w_found_hi | w_found_lo;
        w_sel   = w_found_hi ? w_sel_hi : w_sel_lo;
    end

    // One-hot load strobe: the selected source moves into the output register.
    always_comb begin
        w_load = '0;
        for (int unsigned i = 0; i < NB_SRC; i++) begin
            w_load[i] = w_free & w_found & (w_sel == ID_W'(i));
        end
    end

    // Pending counters with saturation and one-cycle drop flag per source.
    always_ff @(posedge clk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            for (int unsigned i = 0; i < NB_SRC; i++) begin
                r_cnt[i] <= '0;
            end
            r_err <= '0;
        end else begin
            for (int unsigned i = 0; i < NB_SRC; i++) begin
                r_err[i] <= 1'b0;
                if (in_pulse[i] && !w_load[i]) begin
                    if (r_cnt[i] == CNT_MAX) begin
                        r_err[i] <= 1'b1;
                    end else begin
                        r_cnt[i] <= r_cnt[i] + 1'b1;
                    end
                end else if (!in_pulse[i] && w_load[i]) begin
                    r_cnt[i] <= r_cnt[i] - 1'b1;
                end
            end
        end
    end

    // Output register and round-robin pointer; updated only when free.
    always_ff @(posedge clk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            r_vld  <= 1'b0;
            r_id   <= '0;
            r_last <= LAST_RST;
        end else if (w_free) begin
            if (w_found) begin
                r_vld  <= 1'b1;
                r_id   <= w_sel;
                r_last <= w_sel;
            end else begin
                r_vld  <= 1'b0;
            end
        end
    end

    assign out_vld = r_vld;
    assign out_id  = r_id;
    assign error   = r_err;

endmodule
